// File: rtl/cgra_obi_arbiter.sv
// ---------------------------------------------------------------------------
// cgra_obi_arbiter : round-robin OBI arbiter with grant lock and in-order ID FIFO
// Option macro: CGRA_ARB_PORT0_PRIO_EN (port 0 fixed priority).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cgra_obi_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module cgra_obi_arbiter #(
  parameter int  N_PORTS         = 4,
  parameter int  MAX_OUTSTANDING = 4,
  parameter type obi_req_t       = cgra_obi_pkg::obi_req_t,
  parameter type obi_resp_t      = cgra_obi_pkg::obi_resp_t,
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  obi_req_t      req_i  [N_PORTS],
  output obi_resp_t     resp_o [N_PORTS],
  output obi_req_t      master_req_o,
  input  obi_resp_t     master_resp_i,
  output logic [CW-1:0] outstanding_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam int PW = $clog2(N_PORTS);
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [PW-1:0] r_rr_ptr;
  logic          r_lock;
  logic [PW-1:0] r_lock_id;
  logic [PW-1:0] r_fifo [2**AW];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_err;

  logic [PW-1:0] w_sel;
  logic          w_full;
  logic          w_mreq;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_head;
  logic [PW-1:0] w_rr_next;

  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    found = 1'b0;
    idx   = '0;
    w_sel = r_lock_id;
    if (!r_lock) begin
      w_sel = '0;
`ifdef CGRA_ARB_PORT0_PRIO_EN
      if (req_i[0].req) begin
        found = 1'b1;
      end
`endif
      // Port 0 only reaches this scan when it is not requesting, so the
      // prioritised build needs no separate scan for ports 1..N-1.
      for (int k = 0; k < N_PORTS; k++) begin
        idx = PW'((int'(r_rr_ptr) + k) % N_PORTS);
        if (!found && req_i[idx].req) begin
          w_sel = idx;
          found = 1'b1;
        end
      end
    end
  end

  assign w_full    = (r_count == CW'(MAX_OUTSTANDING));
  // Gated by reset so nothing leaks onto the bus while held in reset.
  assign w_mreq    = rst_ni & req_i[w_sel].req & ~w_full;
  assign w_push    = w_mreq & master_resp_i.gnt;
  assign w_pop     = master_resp_i.rvalid & (r_count != '0);
  assign w_head    = r_fifo[r_rd_ptr];
  assign w_rr_next = (w_sel == PW'(N_PORTS - 1)) ? '0 : w_sel + 1'b1;

  always_comb begin
    master_req_o = '0;
    if (w_mreq) begin
      master_req_o = req_i[w_sel];
    end
    for (int i = 0; i < N_PORTS; i++) begin
      resp_o[i]     = '0;
      resp_o[i].gnt = w_push & (w_sel == PW'(i));
      if (w_pop && (w_head == PW'(i))) begin
        resp_o[i].rvalid = 1'b1;
        resp_o[i].rdata  = master_resp_i.rdata;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr  <= '0;
      r_lock    <= 1'b0;
      r_lock_id <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      for (int j = 0; j < 2**AW; j++) begin
        r_fifo[j] <= '0;
      end
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= w_sel;
        r_wr_ptr         <= (r_wr_ptr == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_wr_ptr + 1'b1;
        r_lock           <= 1'b0;
`ifdef CGRA_ARB_PORT0_PRIO_EN
        if (w_sel != '0) begin
          r_rr_ptr <= w_rr_next;
        end
`else
        r_rr_ptr <= w_rr_next;
`endif
      end else if (w_mreq) begin
        r_lock    <= 1'b1;
        r_lock_id <= w_sel;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(MAX_OUTSTANDING - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (master_resp_i.rvalid && (r_count == '0)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign outstanding_o = r_count;
  assign busy_o        = w_mreq | (r_count != '0);
  assign err_o         = r_err;

endmodule

`default_nettype wire
